// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Contents: default data width and queue depth, the zero/discard register
// index (X31), the queue entry struct, and a one-hot helper used for
// pending-mask generation.
package wb_pkg;

  localparam int          WB_N         = 64;
  localparam int          WB_DEPTH_DEF = 4;
  localparam logic [4:0]  REG_ZR       = 5'd31;

  typedef struct packed {
    logic [4:0]      rd;
    logic [WB_N-1:0] data;
    logic            killed;
  } wb_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] m;
    m = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the write-back arbiter's producer, load-return and register
// file signals.
//   master : execute/memory side plus register-file/hazard observers
//            (drives alu_*, ld_valid/ld_rd/ld_data)
//   slave  : the arbiter (drives ld_ready, we3/wa3/wd3, busy, pending_mask)
interface regfile_writeback_if #(
  parameter int N = 64
);
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic [N-1:0] alu_data;
  logic         ld_valid;
  logic         ld_ready;
  logic [4:0]   ld_rd;
  logic [N-1:0] ld_data;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;
  logic         busy;
  logic [31:0]  pending_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  ld_ready, we3, wa3, wd3, busy, pending_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output ld_ready, we3, wa3, wd3, busy, pending_mask
  );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: in-order load-return queue with per-entry kill bits.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push_i, push_ent_i    enqueue an entry at the tail
//   pop_i                 dequeue the head (killed or live)
//   kill_en_i, kill_rd_i  mark every queued entry targeting kill_rd_i as killed,
//                         including one pushed in the same cycle
//   head_o                head entry (killed flag merged in)
//   empty_o, full_o       occupancy flags from the start-of-cycle state
//   mask_o, busy_o        registered live-target mask / any-live flag,
//                         reflecting the state after this cycle's updates
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  wb_entry_t   push_ent_i,
  input  logic        pop_i,
  input  logic        kill_en_i,
  input  logic [4:0]  kill_rd_i,
  output wb_entry_t   head_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [31:0] mask_o,
  output logic        busy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t          mem_q [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [DEPTH-1:0]   kill_q, kill_d;
  logic [PW-1:0]      head_q, tail_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        mask_q, mask_d;
  logic               busy_q;
  logic [4:0]         rd_n [DEPTH];

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign mask_o  = mask_q;
  assign busy_o  = busy_q;

  always_comb begin
    head_o        = mem_q[head_q];
    head_o.killed = kill_q[head_q];
  end

  // Next-state slot view: the same-cycle push is visible to the kill match
  // so an ALU write squashes a load arriving alongside it.
  always_comb begin
    vld_d  = vld_q;
    kill_d = kill_q;
    cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);
    for (int i = 0; i < DEPTH; i++) rd_n[i] = mem_q[i].rd;
    if (pop_i) vld_d[head_q] = 1'b0;
    if (push_i) begin
      vld_d[tail_q]  = 1'b1;
      kill_d[tail_q] = 1'b0;
      rd_n[tail_q]   = push_ent_i.rd;
    end
    if (kill_en_i) begin
      for (int i = 0; i < DEPTH; i++)
        if (vld_d[i] && rd_n[i] == kill_rd_i) kill_d[i] = 1'b1;
    end
    mask_d = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_d[i] && !kill_d[i]) mask_d = mask_d | rd_onehot(rd_n[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      kill_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      kill_q <= kill_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      busy_q <= |mask_d;
      if (pop_i)  head_q <= head_q + 1'b1;
      if (push_i) tail_q <= tail_q + 1'b1;
    end
  end

  // Payload storage carries no reset; slot validity lives in vld_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_ent_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: owns the register file's single write port and
// arbitrates between the fixed-latency ALU path (always wins) and queued
// load returns (drained when the ALU path is idle). Writes to X31 are
// dropped; a later ALU write kills stale queued loads to the same register.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus (slave)  alu_valid/alu_rd/alu_data, ld_valid/ld_ready/ld_rd/ld_data,
//                we3/wa3/wd3 (registered), busy, pending_mask (registered)
// Build option: define WB_LOAD_BYPASS_EN to let a load arriving at an empty
// queue with no ALU traffic go straight to the write port one cycle later.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int N     = WB_N,
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input logic               clk,
  input logic               reset,
  regfile_writeback_if.slave bus
);
  wb_entry_t    head, push_ent;
  logic         empty, full, fifo_busy;
  logic [31:0]  fifo_mask;
  logic         alu_issue, ld_accept, bypass, push, pop;
  logic         we3_q, we3_d;
  logic [4:0]   wa3_q, wa3_d;
  logic [N-1:0] wd3_q, wd3_d;

  assign bus.ld_ready = !reset && !full;
  assign alu_issue    = bus.alu_valid && (bus.alu_rd != REG_ZR);
  assign ld_accept    = bus.ld_valid && bus.ld_ready;

`ifdef WB_LOAD_BYPASS_EN
  assign bypass = ld_accept && empty && (bus.ld_rd != REG_ZR) && !bus.alu_valid;
`else
  assign bypass = 1'b0;
`endif

  // Loads to X31 are accepted and simply dropped here.
  assign push = ld_accept && (bus.ld_rd != REG_ZR) && !bypass;
  assign pop  = !alu_issue && !bypass && !empty;

  always_comb begin
    push_ent        = '0;
    push_ent.rd     = bus.ld_rd;
    push_ent.data   = WB_N'(bus.ld_data);
    push_ent.killed = 1'b0;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .kill_en_i  (alu_issue),
    .kill_rd_i  (bus.alu_rd),
    .head_o     (head),
    .empty_o    (empty),
    .full_o     (full),
    .mask_o     (fifo_mask),
    .busy_o     (fifo_busy)
  );

  // Port selection: ALU, then bypassed load, then queue head (a killed head
  // is consumed without a write).
  always_comb begin
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (alu_issue) begin
      we3_d = 1'b1;
      wa3_d = bus.alu_rd;
      wd3_d = bus.alu_data;
    end else if (bypass) begin
      we3_d = 1'b1;
      wa3_d = bus.ld_rd;
      wd3_d = bus.ld_data;
    end else if (pop && !head.killed) begin
      we3_d = 1'b1;
      wa3_d = head.rd;
      wd3_d = N'(head.data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= we3_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
    end
  end

  assign bus.we3          = we3_q;
  assign bus.wa3          = wa3_q;
  assign bus.wd3          = wd3_q;
  assign bus.busy         = fifo_busy;
  assign bus.pending_mask = fifo_mask;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback: reset, ALU/load latency, ALU
// priority with pending mask, queue full flow control, X31 handling,
// squash of stale loads and reset mid-operation.
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_writeback_if #(.N(64)) bus ();

  regfile_writeback #(.N(64), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [63:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_rd    = rd;
    bus.ld_data  = d;
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] rd, input logic [63:0] d);
    check({tag, ".we3"}, 64'(bus.we3), 64'd1);
    check({tag, ".wa3"}, 64'(bus.wa3), 64'(rd));
    check({tag, ".wd3"}, bus.wd3, d);
  endtask

  initial begin
    idle();
    // Reset held two cycles with both producers active.
    reset = 1'b1;
    alu(5'd3, 64'h77);
    ld(5'd5, 64'h99);
    step(); step();
    check("rst.we3", 64'(bus.we3), 64'd0);
    check("rst.mask", 64'(bus.pending_mask), 64'd0);
    check("rst.ld_ready", 64'(bus.ld_ready), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    idle();
    #1;
    check("rel.ld_ready", 64'(bus.ld_ready), 64'd1);
    step();
    check("rel.we3", 64'(bus.we3), 64'd0);

    // ALU latency one cycle.
    alu(5'd3, 64'h10);
    step();
    idle();
    expect_wr("alu", 5'd3, 64'h10);
    step();
    check("alu.after", 64'(bus.we3), 64'd0);

    // Load latency with no ALU traffic.
    ld(5'd5, 64'hAA);
    step();
    idle();
`ifdef WB_LOAD_BYPASS_EN
    expect_wr("ld.byp", 5'd5, 64'hAA);
    check("ld.byp.mask", 64'(bus.pending_mask), 64'd0);
`else
    check("ld.t1.we3", 64'(bus.we3), 64'd0);
    check("ld.t1.mask", 64'(bus.pending_mask), 64'h20);
    check("ld.t1.busy", 64'(bus.busy), 64'd1);
    step();
    expect_wr("ld.t2", 5'd5, 64'hAA);
    check("ld.t2.mask", 64'(bus.pending_mask), 64'd0);
`endif
    step();

    // Load waits behind three ALU writes.
    alu(5'd1, 64'h101);
    ld(5'd5, 64'hAA);
    step();
    bus.ld_valid = 1'b0;
    expect_wr("pri.x1", 5'd1, 64'h101);
    check("pri.mask1", 64'(bus.pending_mask), 64'h20);
    alu(5'd2, 64'h102);
    step();
    expect_wr("pri.x2", 5'd2, 64'h102);
    check("pri.mask2", 64'(bus.pending_mask), 64'h20);
    alu(5'd4, 64'h104);
    step();
    idle();
    expect_wr("pri.x4", 5'd4, 64'h104);
    check("pri.mask4", 64'(bus.pending_mask), 64'h20);
    step();
    expect_wr("pri.x5", 5'd5, 64'hAA);
    check("pri.mask0", 64'(bus.pending_mask), 64'd0);

    // Fill the queue under a continuous ALU stream.
    for (int i = 0; i < 4; i++) begin
      alu(5'd1, 64'h200 + 64'(i));
      ld(5'(10 + i), 64'hD0 + 64'(i));
      step();
      expect_wr($sformatf("fill%0d", i), 5'd1, 64'h200 + 64'(i));
    end
    check("full.ld_ready", 64'(bus.ld_ready), 64'd0);
    check("full.mask", 64'(bus.pending_mask), 64'h3C00);
    ld(5'd14, 64'hD4);
    alu(5'd1, 64'h204);
    step();
    check("stall.ld_ready", 64'(bus.ld_ready), 64'd0);
    bus.alu_valid = 1'b0;
    step();
    expect_wr("drain0", 5'd10, 64'hD0);
    check("drain0.ld_ready", 64'(bus.ld_ready), 64'd1);
    step();
    bus.ld_valid = 1'b0;
    expect_wr("drain1", 5'd11, 64'hD1);
    for (int i = 2; i < 5; i++) begin
      step();
      expect_wr($sformatf("drain%0d", i), 5'(10 + i), 64'hD0 + 64'(i));
    end
    check("drain.mask", 64'(bus.pending_mask), 64'd0);
    check("drain.busy", 64'(bus.busy), 64'd0);
    step();
    check("drain.idle", 64'(bus.we3), 64'd0);

    // X31 from both producers.
    alu(5'd31, 64'h31);
    step();
    idle();
    check("x31.alu", 64'(bus.we3), 64'd0);
    ld(5'd31, 64'h31);
    #1;
    check("x31.ld_ready", 64'(bus.ld_ready), 64'd1);
    step();
    idle();
    check("x31.ld.we3", 64'(bus.we3), 64'd0);
    check("x31.ld.mask", 64'(bus.pending_mask), 64'd0);
    step();
    check("x31.ld.never", 64'(bus.we3), 64'd0);

    // Squash: queued X7 made stale by an ALU write to X7.
    alu(5'd2, 64'h22);
    ld(5'd7, 64'h11);
    step();
    bus.ld_valid = 1'b0;
    expect_wr("sq.x2", 5'd2, 64'h22);
    check("sq.mask7", 64'(bus.pending_mask), 64'h80);
    alu(5'd7, 64'h55);
    step();
    idle();
    expect_wr("sq.x7", 5'd7, 64'h55);
    check("sq.mask0", 64'(bus.pending_mask), 64'd0);
    check("sq.busy", 64'(bus.busy), 64'd0);
    step();
    check("sq.killpop", 64'(bus.we3), 64'd0);
    step();
    check("sq.after", 64'(bus.we3), 64'd0);

    // Reset mid-operation discards queued loads.
    alu(5'd1, 64'h1);
    ld(5'd9, 64'h99);
    step();
    idle();
    check("mid.mask", 64'(bus.pending_mask), 64'h200);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid.rst.mask", 64'(bus.pending_mask), 64'd0);
    check("mid.rst.wa3", 64'(bus.wa3), 64'd0);
    step();
    check("mid.nowrite", 64'(bus.we3), 64'd0);
    step();
    check("mid.nowrite2", 64'(bus.we3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back arbiter that owns the register file's single write port (`we3`/`wa3`/`wd3`) and drives it from two producers: the fixed-latency ALU result path and the variable-latency load-return path. ALU results always win the port; load returns are buffered in a small in-order queue and drained whenever the ALU path is idle. The block sits between the execute/memory stages and the register file. It drops writes to X31 and squashes queued loads that a later ALU write to the same register makes stale. It exports a pending-write mask for hazard logic.

## Interface
- `N`, 64, data width (matches register file)
- `DEPTH`, 4, load queue entries (power of two, ≥2)
- `clk` in 1, system clock, rising edge
- `reset` in 1, synchronous, active-high
- `alu_valid` in 1, ALU result present this cycle (no backpressure)
- `alu_rd` in 5, ALU destination register
- `alu_data` in N, ALU result
- `ld_valid` in 1, load return valid
- `ld_ready` out 1, queue can accept a load return; transfer when `ld_valid && ld_ready`
- `ld_rd` in 5, load destination register
- `ld_data` in N, load data
- `we3` out 1, register file write enable (registered)
- `wa3` out 5, register file write address (registered)
- `wd3` out N, register file write data (registered)
- `busy` out 1, at least one live (non-killed) queued load
- `pending_mask` out 32, bit r set iff a live queued load targets register r

## Operation
- **One write per cycle.** Selection is evaluated at the start of the cycle, in this order:
  - `alu_valid && alu_rd != 31`: the ALU result is issued.
  - Otherwise, if the queue head is live: the head is popped and issued.
  - Otherwise, if the queue head is killed: the head is popped silently, with `we3=0`.
  - Otherwise: `we3=0`.
- **Loads.** An accepted load with `ld_rd != 31` is pushed at the tail. An accepted load with `ld_rd == 31` is consumed and discarded.
- **Flow control.** `ld_ready = !full`, computed from the state at the start of the cycle. There is no same-cycle pass-through when full; a push and a pop in the same cycle are both legal when not full. The upstream source holds `ld_rd`/`ld_data` stable while `ld_valid && !ld_ready`.
- **Squash.** An ALU write to register r kills every queued entry with rd==r, including an entry pushed in the same cycle. Ordering rule: ALU results are always younger than queued loads.
- **X31 from the ALU.** An ALU write with `alu_rd == 31` issues nothing and kills nothing. The head may be popped in that cycle.
- **Starvation.** There is no starvation guard: continuous `alu_valid` starves the queue, and `ld_ready` falls once the queue is full.
- **Hazard outputs.** `pending_mask` and `busy` are registered and reflect the queue contents after the cycle's push, pop and kill.
- **Reset values:**
  - `we3=0`, `wa3=0`, `wd3=0`, `busy=0`, `pending_mask=0`.
  - The queue is emptied and all kill bits cleared.
  - `ld_ready=0` while `reset` is high, then 1 from the first cycle after release.
- **Reset mid-operation** discards all queued loads without writing them.

## Timing
- **ALU latency:** `alu_valid` in cycle t gives `we3=1` in cycle t+1; the register file commits at the end of t+1.
- **Load latency:** a load accepted in cycle t with no ALU traffic gives `we3` in t+2, or t+1 with bypass (see Configuration).
- **Queue pointers:** wrap modulo `DEPTH`. The occupancy counter is `$clog2(DEPTH)+1` bits and goes 0..`DEPTH`.
- **Busy path:** a full queue under a continuous ALU stream keeps `ld_ready=0` indefinitely.
- **Killed entries** still occupy a slot until they are popped.

## Configuration
- **`WB_LOAD_BYPASS_EN` defined:** a load accepted in cycle t is issued directly in t+1, without entering the queue, when all three hold:
  - the queue is empty at the start of t;
  - the load target is not X31;
  - `alu_valid` is low in t.
  
  A bypassed load never sets `pending_mask`.
- **Undefined:** every accepted load passes through the queue, giving a minimum latency of 2.
- All other behaviour is identical in both configurations.

## Structure
- **Package `wb_pkg`:**
  - `wb_entry_t` struct: `rd[4:0]`, `data[N-1:0]`, `killed`.
  - `REG_ZR = 5'd31`.
  - Default depth constant.
- **Sub-module `wb_fifo`:** circular buffer with per-entry kill bits, a match-and-kill port (rd), and mask generation. The top level holds the selection logic and the output registers.

## Test plan
- Hold `reset` 2 cycles with `alu_valid=1`, `ld_valid=1` → `we3=0`, `pending_mask=0`, `ld_ready=0`; the cycle after release, `ld_ready=1`.
- ALU `alu_rd=3`, `alu_data=0x10` in t → in t+1, `we3=1`, `wa3=3`, `wd3=0x10`. A load to X5, 0xAA, with no ALU traffic:
  - without the macro → write in t+2;
  - with `WB_LOAD_BYPASS_EN` → write in t+1.
- Load X5 0xAA accepted while the ALU writes X1, X2, X4 on consecutive cycles → `pending_mask[5]=1` throughout; writes X1, X2, X4, then X5=0xAA in the cycle after `alu_valid` drops.
- With the ALU busy, issue 5 loads, `DEPTH=4` → `ld_ready=0` after the 4th is accepted; the 5th is held stable and accepted on the first pop; all 5 are written in order.
- `alu_rd=31` → `we3` stays 0. A load with `ld_rd=31` → accepted, `pending_mask` unchanged, never written.
- Queue load X7 0x11, then ALU X7 0x55 → exactly one write, `wa3=7`, `wd3=0x55`; `pending_mask[7]` clears; the killed entry pops with `we3=0`.
